// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the instruction fetch port and the
// load/store port. Each access takes LAT busy cycles plus one completion
// cycle, and the data port is capped at MAX_D back-to-back grants while
// fetch is waiting.
module mem_port_arbiter #(
  parameter int LAT   = 1,
  parameter int MAX_D = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  // fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          IFstall,
  // load/store port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          Memstall,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_data
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int SW = $clog2(MAX_D + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   dstreak_q, dstreak_d;
  logic            acc_we_q, acc_we_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            if_done_q, if_done_d;
  logic            d_done_q, d_done_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_adr_q, mem_adr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            gnt_data_q, gnt_data_d;

  logic            grant_d;
  logic            grant_i;
  logic            streak_full;
  logic            cnt_zero;

  assign streak_full = (dstreak_q == SW'(MAX_D));
  assign cnt_zero    = (cnt_q == '0);

  // Arbitration: data wins a tie unless it has used up its streak budget.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && !(if_req && streak_full)) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  // Data streak: counts data grants that made fetch wait, saturating at MAX_D.
  always_comb begin
    dstreak_d = dstreak_q;
    if (grant_i) begin
      dstreak_d = '0;
    end else if (grant_d) begin
      if (!if_req) begin
        dstreak_d = '0;
      end else if (!streak_full) begin
        dstreak_d = dstreak_q + SW'(1);
      end
    end
  end

  // Access sequencing: grant, latency countdown, read capture and completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    // write qualifiers are only meaningful alongside the single mem_en cycle
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    mem_adr_d   = mem_adr_q;
    gnt_data_d  = gnt_data_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          cnt_d       = CW'(LAT - 1);
          acc_we_d    = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_adr_d   = d_adr;
          mem_wdata_d = d_wdata;
          gnt_data_d  = 1'b1;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          cnt_d       = CW'(LAT - 1);
          acc_we_d    = 1'b0;
          mem_en_d    = 1'b1;
          mem_adr_d   = if_adr;
        end
      end

      BUSY_I: begin
        if (cnt_zero) begin
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      BUSY_D: begin
        if (cnt_zero) begin
          // stores complete on the same schedule but leave d_rdata alone
          if (!acc_we_q) begin
            d_rdata_d = mem_rdata;
          end
          d_done_d   = 1'b1;
          gnt_data_d = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        // requester refreshes its request here, so no grant is made this cycle
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dstreak_q <= '0;
      acc_we_q  <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      mem_en_q  <= 1'b0;
      gnt_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dstreak_q <= dstreak_d;
      acc_we_q  <= acc_we_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      mem_en_q  <= mem_en_d;
      gnt_data_q <= gnt_data_d;
    end
  end

  // Address, write data and returned read data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign d_rdata   = d_rdata_q;
  assign d_done    = d_done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign gnt_data  = gnt_data_q;

  // Stalls follow the request directly and drop in the completion cycle.
  assign IFstall  = if_req & ~if_done_q;
  assign Memstall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=1 and LAT=3) checked every
// cycle against a transaction-timeline reference model, plus directed scenarios.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MAX_D = 4;

  logic        clk;
  logic        reset;
  logic        if_req    [2];
  logic [31:0] if_adr    [2];
  logic [31:0] if_rdata  [2];
  logic        if_done   [2];
  logic        IFstall   [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_adr     [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] d_rdata   [2];
  logic        d_done    [2];
  logic        Memstall  [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_adr   [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        gnt_data  [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit primed;
  bit rst_prev;

  // memory seen by the DUTs (environment side)
  logic [31:0] emem [2][64];
  int          age    [2];
  logic [31:0] rd_val [2];

  // reference model: current transaction on a timeline plus its own memory image
  logic [31:0] mmem [2][64];
  bit          act     [2];
  bit          own_d   [2];
  bit          t_we    [2];
  logic [31:0] t_adr   [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rd    [2];
  int          g       [2];
  int          streak  [2];
  logic [31:0] x_if_rdata [2];
  logic [31:0] x_d_rdata  [2];
  bit          x_if_done  [2];
  bit          x_d_done   [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(1), .MAX_D(MAX_D), .AW(AW), .DW(DW)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req[0]), .if_adr(if_adr[0]), .if_rdata(if_rdata[0]),
    .if_done(if_done[0]), .IFstall(IFstall[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_adr(d_adr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_done(d_done[0]), .Memstall(Memstall[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_adr(mem_adr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .gnt_data(gnt_data[0])
  );

  mem_port_arbiter #(.LAT(3), .MAX_D(MAX_D), .AW(AW), .DW(DW)) u_dut_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req[1]), .if_adr(if_adr[1]), .if_rdata(if_rdata[1]),
    .if_done(if_done[1]), .IFstall(IFstall[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_adr(d_adr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_done(d_done[1]), .Memstall(Memstall[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_adr(mem_adr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .gnt_data(gnt_data[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic string tg(input int k, input string name);
    return $sformatf("L%0d %s", lat_of(k), name);
  endfunction

  task automatic new_if(input int k);
    if_adr[k] = 32'($urandom_range(0, 63)) << 2;
  endtask

  task automatic new_d(input int k);
    d_we[k]    = 1'($urandom_range(0, 1));
    d_adr[k]   = 32'($urandom_range(0, 63)) << 2;
    d_wdata[k] = $urandom;
  endtask

  // Model: at the end of a cycle, if the port is idle, decide the next grant.
  task automatic model_edge(input int k);
    int ai;
    if (reset) begin
      act[k] = 1'b0;
      streak[k] = 0;
      x_if_rdata[k] = '0;
      x_d_rdata[k] = '0;
      return;
    end
    if (act[k] && cyc < g[k] + lat_of(k) + 2) return;
    act[k] = 1'b0;
    if (d_req[k] && !(if_req[k] && streak[k] == MAX_D)) begin
      ai = int'(d_adr[k][7:2]);
      act[k] = 1'b1; own_d[k] = 1'b1; t_we[k] = d_we[k];
      t_adr[k] = d_adr[k]; t_wdata[k] = d_wdata[k]; g[k] = cyc;
      streak[k] = if_req[k] ? ((streak[k] < MAX_D) ? streak[k] + 1 : MAX_D) : 0;
      if (d_we[k]) mmem[k][ai] = d_wdata[k];
      else t_rd[k] = mmem[k][ai];
    end else if (if_req[k]) begin
      ai = int'(if_adr[k][7:2]);
      act[k] = 1'b1; own_d[k] = 1'b0; t_we[k] = 1'b0;
      t_adr[k] = if_adr[k]; t_wdata[k] = '0; g[k] = cyc;
      streak[k] = 0;
      t_rd[k] = mmem[k][ai];
    end
  endtask

  // Model: expected registered outputs in the current cycle.
  task automatic model_expect(input int k);
    bit en, busy, dn;
    if (rst_prev) begin
      x_if_done[k] = 1'b0;
      x_d_done[k]  = 1'b0;
      check_eq(tg(k, "rst mem_en"), mem_en[k], 0);
      check_eq(tg(k, "rst mem_we"), mem_we[k], 0);
      check_eq(tg(k, "rst mem_adr"), mem_adr[k], 0);
      check_eq(tg(k, "rst mem_wdata"), mem_wdata[k], 0);
      check_eq(tg(k, "rst gnt_data"), gnt_data[k], 0);
      check_eq(tg(k, "rst if_done"), if_done[k], 0);
      check_eq(tg(k, "rst d_done"), d_done[k], 0);
      check_eq(tg(k, "rst if_rdata"), if_rdata[k], 0);
      check_eq(tg(k, "rst d_rdata"), d_rdata[k], 0);
      return;
    end
    en   = act[k] && (cyc == g[k] + 1);
    busy = act[k] && (cyc >= g[k] + 1) && (cyc <= g[k] + lat_of(k));
    dn   = act[k] && (cyc == g[k] + lat_of(k) + 1);
    if (dn && !own_d[k]) x_if_rdata[k] = t_rd[k];
    if (dn && own_d[k] && !t_we[k]) x_d_rdata[k] = t_rd[k];
    x_if_done[k] = dn && !own_d[k];
    x_d_done[k]  = dn && own_d[k];
    check_eq(tg(k, "mem_en"), mem_en[k], 32'(en));
    check_eq(tg(k, "mem_we"), mem_we[k], 32'(en && own_d[k] && t_we[k]));
    check_eq(tg(k, "gnt_data"), gnt_data[k], 32'(busy && own_d[k]));
    check_eq(tg(k, "if_done"), if_done[k], 32'(x_if_done[k]));
    check_eq(tg(k, "d_done"), d_done[k], 32'(x_d_done[k]));
    check_eq(tg(k, "if_rdata"), if_rdata[k], x_if_rdata[k]);
    check_eq(tg(k, "d_rdata"), d_rdata[k], x_d_rdata[k]);
    if (en) check_eq(tg(k, "mem_adr"), mem_adr[k], t_adr[k]);
    if (en && own_d[k] && t_we[k]) check_eq(tg(k, "mem_wdata"), mem_wdata[k], t_wdata[k]);
    if (!(busy && own_d[k])) check_eq(tg(k, "mem_wdata idle"), mem_wdata[k], 0);
  endtask

  // Environment memory: read data is valid only in access cycle LAT.
  task automatic env_drive(input int k);
    int ai;
    ai = int'(mem_adr[k][7:2]);
    if (mem_en[k]) begin
      if (mem_we[k]) emem[k][ai] = mem_wdata[k];
      else rd_val[k] = emem[k][ai];
      age[k] = 1;
    end else if (age[k] > 0 && age[k] < 100) begin
      age[k]++;
    end
    mem_rdata[k] = (age[k] == lat_of(k)) ? rd_val[k] : $urandom;
  endtask

  // One clock: check stalls on current inputs, advance the model, check outputs.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (primed) begin
        check_eq(tg(k, "IFstall"), IFstall[k], 32'(if_req[k] & ~x_if_done[k]));
        check_eq(tg(k, "Memstall"), Memstall[k], 32'(d_req[k] & ~x_d_done[k]));
      end
      model_edge(k);
    end
    rst_prev = reset;
    @(posedge clk);
    #1;
    cyc++;
    primed = 1'b1;
    for (int k = 0; k < 2; k++) begin
      model_expect(k);
      env_drive(k);
    end
  endtask

  initial begin
    int n_gr;
    bit seen;
    logic [31:0] keep;
    logic [31:0] v;

    reset = 1'b1;
    primed = 1'b0;
    rst_prev = 1'b0;
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; streak[k] = 0; age[k] = 100; rd_val[k] = '0;
      x_if_rdata[k] = '0; x_d_rdata[k] = '0; x_if_done[k] = 1'b0; x_d_done[k] = 1'b0;
      mem_rdata[k] = '0;
      for (int i = 0; i < 64; i++) begin
        v = $urandom;
        emem[k][i] = v;
        mmem[k][i] = v;
      end
      // both ports requesting across reset
      if_req[k] = 1'b1; d_req[k] = 1'b1;
      new_if(k); new_d(k);
    end
    step();
    step();
    reset = 1'b0;

    // fairness with both ports continuously requesting
    n_gr = 0;
    repeat (80) begin
      step();
      if (mem_en[0]) begin
        check_eq("fair_owner", gnt_data[0], (n_gr % 5 == 4) ? 32'd0 : 32'd1);
        n_gr++;
      end
      for (int k = 0; k < 2; k++) begin
        if (if_done[k]) new_if(k);
        if (d_done[k]) new_d(k);
      end
    end
    check_eq("fair_grant_count", 32'(n_gr >= 20), 1);

    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; d_req[k] = 1'b0;
    end
    repeat (6) step();

    // single fetch, LAT=1
    emem[0][16] = 32'h8C22_0004; mmem[0][16] = 32'h8C22_0004;
    if_adr[0] = 32'h40; if_req[0] = 1'b1;
    #1 check_eq("fetch_stall_T", IFstall[0], 1);
    step();
    check_eq("fetch_en", mem_en[0], 1);
    check_eq("fetch_adr", mem_adr[0], 32'h40);
    check_eq("fetch_we", mem_we[0], 0);
    #1 check_eq("fetch_stall_T1", IFstall[0], 1);
    step();
    check_eq("fetch_done", if_done[0], 1);
    check_eq("fetch_rdata", if_rdata[0], 32'h8C22_0004);
    #1 check_eq("fetch_stall_T2", IFstall[0], 0);
    if_req[0] = 1'b0;
    step();

    // load and fetch arriving together, LAT=1
    emem[0][4] = 32'h1111_0010; mmem[0][4] = 32'h1111_0010;
    d_we[0] = 1'b0; d_adr[0] = 32'h10; d_wdata[0] = $urandom; d_req[0] = 1'b1;
    if_adr[0] = 32'h44; if_req[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      case (i)
        1: begin
          check_eq("both_d_en", mem_en[0], 1);
          check_eq("both_d_gnt", gnt_data[0], 1);
        end
        2: begin
          check_eq("both_d_done", d_done[0], 1);
          check_eq("both_d_rdata", d_rdata[0], 32'h1111_0010);
          d_req[0] = 1'b0;
        end
        4: begin
          check_eq("both_i_en", mem_en[0], 1);
          check_eq("both_i_adr", mem_adr[0], 32'h44);
        end
        5: begin
          check_eq("both_i_done", if_done[0], 1);
          if_req[0] = 1'b0;
        end
        default: ;
      endcase
    end
    step();

    // store, LAT=3
    keep = x_d_rdata[1];
    d_we[1] = 1'b1; d_adr[1] = 32'h20; d_wdata[1] = 32'hDEAD_BEEF; d_req[1] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      case (i)
        1: begin
          check_eq("st_en", mem_en[1], 1);
          check_eq("st_we", mem_we[1], 1);
          check_eq("st_wdata", mem_wdata[1], 32'hDEAD_BEEF);
        end
        2: begin
          check_eq("st_en_T2", mem_en[1], 0);
          check_eq("st_we_T2", mem_we[1], 0);
        end
        3: check_eq("st_done_T3", d_done[1], 0);
        4: begin
          check_eq("st_done", d_done[1], 1);
          check_eq("st_rdata_kept", d_rdata[1], keep);
          d_req[1] = 1'b0;
        end
        default: ;
      endcase
    end
    step();
    step();

    // reset in the middle of a LAT=3 load, then recovery
    d_we[1] = 1'b0; d_adr[1] = 32'h24; d_req[1] = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("rst_mid_done", d_done[1], 0);
    check_eq("rst_mid_en", mem_en[1], 0);
    check_eq("rst_mid_gnt", gnt_data[1], 0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (d_done[1]) begin
        seen = 1'b1;
        check_eq("rst_recover_rdata", d_rdata[1], mmem[1][9]);
        d_req[1] = 1'b0;
      end
    end
    check_eq("rst_recover_done", 32'(seen), 1);

    // randomized traffic with occasional reset
    repeat (3000) begin
      reset = ($urandom_range(0, 299) == 0);
      step();
      for (int k = 0; k < 2; k++) begin
        if (if_done[k] || !if_req[k]) begin
          if_req[k] = ($urandom_range(0, 2) != 0);
          new_if(k);
        end
        if (d_done[k] || !d_req[k]) begin
          d_req[k] = ($urandom_range(0, 2) != 0);
          new_d(k);
        end
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; d_req[k] = 1'b0;
    end
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
